// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses PLL reset, waits for a stable lock,
// then releases downstream reset; retries on timeout, faults when exhausted.
module pll_lock_sequencer #(
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int MAX_RETRIES      = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_AB =
    (RST_HOLD_CYC > LOCK_TIMEOUT_CYC) ? RST_HOLD_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_C =
    (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] C_HOLD = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] C_TOUT = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] C_STAB = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]    C_MAXR = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    r_retry;
  logic [3:0]    w_retry_nxt;
  logic [7:0]    r_loss;
  logic [7:0]    w_loss_nxt;
  logic          r_sync1;
  logic          r_sync2;
  logic          w_locked_s;
  logic          r_pll_rst;
  logic          r_sys_rst_n;
  logic          r_ready;
  logic          r_fault;
  logic          w_pll_rst_nxt;
  logic          w_run_nxt;
  logic          w_fault_nxt;

  assign w_locked_s = r_sync2;

  // Next state, shared counter, retry/loss bookkeeping; restart wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    if (restart) begin
      w_state_nxt = S_RESET_PLL;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == C_HOLD) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_state_nxt = S_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_TOUT) begin
            w_cnt_nxt = '0;
            if (r_retry < C_MAXR) begin
              w_state_nxt = S_RESET_PLL;
              w_retry_nxt = r_retry + 1'b1;
            end else begin
              w_state_nxt = S_FAULT;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!w_locked_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_STAB) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          w_cnt_nxt = '0;
          if (!w_locked_s) begin
            w_state_nxt = S_RESET_PLL;
            w_retry_nxt = '0;
            if (r_loss != 8'hFF) begin
              w_loss_nxt = r_loss + 1'b1;
            end
          end
        end
        S_FAULT: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output values decoded from the next state so they move with it.
  always_comb begin
    w_pll_rst_nxt = (w_state_nxt == S_RESET_PLL) ||
                    (w_state_nxt == S_FAULT);
    w_run_nxt     = (w_state_nxt == S_RUN);
    w_fault_nxt   = (w_state_nxt == S_FAULT);
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state     <= S_RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_loss      <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_loss      <= w_loss_nxt;
      r_sync1     <= pll_locked;
      r_sync2     <= r_sync1;
      r_pll_rst   <= w_pll_rst_nxt;
      r_sys_rst_n <= w_run_nxt;
      r_ready     <= w_run_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst_n     = r_sys_rst_n;
  assign ready         = r_ready;
  assign fault         = r_fault;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random
// lock/restart/reset traffic, all checked against a timeline model.
module tb_pll_lock_sequencer;

  localparam int H  = 4;
  localparam int T  = 20;
  localparam int S  = 8;
  localparam int MR = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FLT  = 4;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int m_ph    = P_RST;
  int m_t0    = 0;
  int m_now   = 0;
  int m_retry = 0;
  int m_loss  = 0;
  bit m_s1    = 1'b0;
  bit m_s2    = 1'b0;

  pll_lock_sequencer #(
    .RST_HOLD_CYC(H),
    .LOCK_TIMEOUT_CYC(T),
    .LOCK_STABLE_CYC(S),
    .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .restart(restart),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #10 refclk = ~refclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic enter(input int p);
    m_ph = p;
    m_t0 = m_now;
  endtask

  // Advance the model by one edge using the inputs seen at that edge.
  task automatic model_step();
    int el;
    bit ls;
    m_now++;
    el = m_now - m_t0;
    ls = m_s2;
    if (!rst_n) begin
      enter(P_RST);
      m_retry = 0;
      m_loss  = 0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
    end else begin
      if (restart) begin
        enter(P_RST);
        m_retry = 0;
      end else begin
        case (m_ph)
          P_RST:  if (el == H) enter(P_WAIT);
          P_WAIT: begin
            if (ls) enter(P_STAB);
            else if (el == T) begin
              if (m_retry < MR) begin
                m_retry++;
                enter(P_RST);
              end else begin
                enter(P_FLT);
              end
            end
          end
          P_STAB: begin
            if (!ls) enter(P_WAIT);
            else if (el == S) enter(P_RUN);
          end
          P_RUN: begin
            if (!ls) begin
              enter(P_RST);
              m_retry = 0;
              if (m_loss < 255) m_loss++;
            end
          end
          default: ;
        endcase
      end
      m_s2 = m_s1;
      m_s1 = pll_locked;
    end
  endtask

  function automatic logic [15:0] model_vec();
    logic pr;
    logic rn;
    logic fl;
    pr = (m_ph == P_RST) || (m_ph == P_FLT);
    rn = (m_ph == P_RUN);
    fl = (m_ph == P_FLT);
    return {pr, rn, rn, fl, 4'(m_retry), 8'(m_loss)};
  endfunction

  task automatic cyc();
    @(posedge refclk);
    #1;
    model_step();
    chk("outputs",
        {16'h0, pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt},
        {16'h0, model_vec()});
  endtask

  task automatic wait_rst_low();
    int k;
    k = 0;
    while (pll_rst && k < 100) begin
      cyc();
      k++;
    end
    chk("pll_rst_fall_wait", {31'h0, pll_rst}, 32'h0);
  endtask

  task automatic measure_ready(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ready && n < 60);
  endtask

  task automatic get_run();
    int n;
    wait_rst_low();
    pll_locked = 1'b1;
    measure_ready(n);
    chk("reach_run", {31'h0, ready}, 32'h1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {16'h0, pll_rst, sys_rst_n, ready, fault,
              retry_cnt, lock_loss_cnt},
        {16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h0});
  endtask

  initial begin
    int n;
    int pulses;
    int idx;
    logic prev;

    rst_n = 1'b0;
    repeat (3) cyc();
    chk_reset_vals("reset_state");

    rst_n = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (pll_rst && n < 50);
    chk("nominal_rst_hold", n, H);
    repeat (5) cyc();
    pll_locked = 1'b1;
    measure_ready(n);
    chk("nominal_ready_lat", n, 3 + S);
    chk("nominal_sys_rst_n", {31'h0, sys_rst_n}, 32'h1);
    chk("nominal_retry", {28'h0, retry_cnt}, 32'h0);

    pll_locked = 1'b0;
    cyc();
    cyc();
    chk("loss_ready_hold", {31'h0, ready}, 32'h1);
    cyc();
    chk("loss_outs", {29'h0, ready, sys_rst_n, pll_rst}, 32'h1);
    chk("loss_cnt", {24'h0, lock_loss_cnt}, 32'h1);
    get_run();

    pll_locked = 1'b0;
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    wait_rst_low();
    pll_locked = 1'b1;
    repeat (3) cyc();
    pll_locked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("glitch_ready_low", {31'h0, ready}, 32'h0);
    end
    chk("glitch_in_wait", {31'h0, pll_rst}, 32'h0);
    pll_locked = 1'b1;
    measure_ready(n);
    chk("glitch_relock_lat", n, 3 + S);

    pll_locked = 1'b0;
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    pulses = 0;
    idx = 0;
    prev = pll_rst;
    for (int k = 0; k < 300 && !fault; k++) begin
      cyc();
      if (prev && !pll_rst) pulses++;
      if (!prev && pll_rst && !fault) begin
        chk($sformatf("retry_step%0d", idx + 1), {28'h0, retry_cnt}, idx + 1);
        idx++;
      end
      prev = pll_rst;
    end
    chk("timeout_fault", {31'h0, fault}, 32'h1);
    chk("timeout_pulses", pulses, 3);
    chk("timeout_retry_steps", idx, MR);
    chk("fault_retry", {28'h0, retry_cnt}, MR);
    repeat (5) cyc();
    chk("fault_sticky", {30'h0, fault, pll_rst}, 32'h3);

    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_outs", {27'h0, fault, retry_cnt}, 32'h0);
    chk("restart_pll_rst", {31'h0, pll_rst}, 32'h1);
    n = 0;
    do begin
      cyc();
      n++;
    end while (pll_rst && n < 50);
    chk("restart_rst_hold", n, H);
    repeat (T - 1) cyc();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_wins", {27'h0, pll_rst, retry_cnt}, 32'h10);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 11) == 0) pll_locked = ~pll_locked;
      restart = ($urandom_range(0, 49) == 0);
      rst_n   = ($urandom_range(0, 99) != 0);
      cyc();
    end
    restart = 1'b0;
    rst_n = 1'b1;

    rst_n = 1'b0;
    pll_locked = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_run();
      pll_locked = 1'b0;
      repeat (3) cyc();
    end
    get_run();
    chk("midreset_loss5", {24'h0, lock_loss_cnt}, 32'h5);
    rst_n = 1'b0;
    cyc();
    chk_reset_vals("midreset_outs");
    rst_n = 1'b1;
    pll_locked = 1'b0;
    repeat (10) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_HOLD_CYC, default 16: cycles pll_rst is held high per reset attempt (min 2).
REQ-002 Parameter LOCK_TIMEOUT_CYC, default 50000: cycles allowed for lock after pll_rst release (1 ms at 50 MHz).
REQ-003 Parameter LOCK_STABLE_CYC, default 256: cycles synchronized lock must stay high before release.
REQ-004 Parameter MAX_RETRIES, default 3: re-reset attempts after the first timeout before fault (0..15).
REQ-005 refclk  in  1  50 MHz reference clock; sole clock of the block.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
REQ-008 restart  in  1  single-cycle request to re-run the full sequence.
REQ-009 pll_rst  out  1  reset to the PLL, active-high.
REQ-010 sys_rst_n  out  1  active-low reset for logic clocked by the PLL output.
REQ-011 ready  out  1  PLL locked and stable.
REQ-012 fault  out  1  retries exhausted; sticky until restart or rst_n.
REQ-013 retry_cnt  out  4  timeouts in the current sequence.
REQ-014 lock_loss_cnt  out  8  lock losses seen in RUN, saturating at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (locked_s) before use; all lock decisions use locked_s only.
REQ-016 FSM states SHALL be RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT, with one shared cycle counter cleared on every state change.
REQ-017 RESET_PLL: pll_rst=1; after RST_HOLD_CYC cycles in state -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; counter at LOCK_TIMEOUT_CYC-1 with locked_s=0 -> RESET_PLL with retry_cnt+1 if retry_cnt<MAX_RETRIES, else FAULT.
REQ-019 STABLE: locked_s=0 -> WAIT_LOCK (fresh timeout); LOCK_STABLE_CYC consecutive cycles of locked_s=1 -> RUN.
REQ-020 RUN: ready=1, sys_rst_n=1; locked_s=0 -> RESET_PLL, retry_cnt cleared, lock_loss_cnt+1 (saturating).
REQ-021 FAULT: pll_rst=1, fault=1, ready=0, sys_rst_n=0; exits only on restart or rst_n.
REQ-022 restart=1 in any state SHALL force RESET_PLL with counter and retry_cnt cleared, taking priority over all other transitions; lock_loss_cnt is kept.
REQ-023 All outputs SHALL be registered and glitch-free; each output takes its new-state value on the same edge the state register updates.
REQ-024 sys_rst_n and ready SHALL be 1 only in RUN; deassertion of ready and sys_rst_n on lock loss SHALL occur on the same edge as the RUN exit.
REQ-025 Latency: pll_locked rise to STABLE entry = 3 edges (2 sync + 1 FSM); STABLE entry to ready=1 = LOCK_STABLE_CYC edges.
REQ-026 Counter width SHALL fit the largest of the three cycle parameters; counters SHALL never wrap.

Reset
REQ-027 rst_n=0 at a refclk edge SHALL set state=RESET_PLL, counter=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0, regardless of the current state.
REQ-028 After rst_n returns high, the sequence SHALL start from RESET_PLL with a full RST_HOLD_CYC hold.

Verification (bench params: RST_HOLD_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRIES=2)
REQ-029 Nominal: release rst_n, raise pll_locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; ready=1 and sys_rst_n=1 on the same edge, 3+8 edges after the pll_locked rise; retry_cnt=0.
REQ-030 Lock glitch: pll_locked high 3 cycles then low during STABLE -> returns to WAIT_LOCK, ready stays 0; re-lock then needs a full 8 stable cycles.
REQ-031 Timeouts: pll_locked held 0 -> 3 pll_rst pulses of 4 cycles each; retry_cnt steps 1, 2; on the third timeout fault=1, pll_rst=1 held, retry_cnt=2.
REQ-032 Lock loss: in RUN, drop pll_locked -> 3 edges later ready=0, sys_rst_n=0, pll_rst=1, lock_loss_cnt=1; the sequence re-runs to RUN on re-lock.
REQ-033 Restart: in FAULT, pulse restart -> next edge fault=0, retry_cnt=0, pll_rst=1 for 4 cycles; restart coincident with a timeout edge -> restart wins.
REQ-034 Mid-operation reset: assert rst_n=0 for 1 cycle while in RUN with lock_loss_cnt=5 -> all outputs at REQ-027 values on that edge, lock_loss_cnt=0.
